// File: rtl/tw4_prog_loader_if.sv
// tw4_prog_loader_if: load stream and CPU fetch/reset signals of the TW4 program loader.
interface tw4_prog_loader_if #(parameter int ADDR_W = 6);
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_last;
    logic              load_ready;
    logic              reload;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_reset_n;
    logic              loading;
    logic [ADDR_W:0]   load_count;
    logic              load_err;

    modport slave (
        input  load_valid, load_data, load_last, reload, cpu_addr,
        output load_ready, cpu_data, cpu_reset_n, loading, load_count, load_err
    );

    modport master (
        output load_valid, load_data, load_last, reload, cpu_addr,
        input  load_ready, cpu_data, cpu_reset_n, loading, load_count, load_err
    );
endinterface

// File: rtl/tw4_prog_loader.sv
// tw4_prog_loader: 64x8 program store filled from a byte stream, zero-padded, then served to the TW4 core.
module tw4_prog_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input logic                clock,
    input logic                reset,
    tw4_prog_loader_if.slave   bus
);
    typedef enum logic [1:0] {S_LOAD, S_FILL, S_RUN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_cpu_reset_n;
    logic              r_err;
    logic [7:0]        r_mem [DEPTH];
    logic              w_accept;
    logic              w_fill;
    logic              w_at_end;

    assign w_accept = (r_state == S_LOAD) && bus.load_valid;
    assign w_fill   = (r_state == S_FILL);
    assign w_at_end = (r_wr_ptr == ADDR_W'(DEPTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  w_next = !w_accept ? S_LOAD : w_at_end ? S_RUN : bus.load_last ? S_FILL : S_LOAD;
            S_FILL:  w_next = w_at_end ? S_RUN : S_FILL;
            default: w_next = bus.reload ? S_LOAD : S_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_cpu_reset_n <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_cpu_reset_n <= (w_next == S_RUN);
            if (w_accept || w_fill)
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_accept)
                r_count <= r_count + (ADDR_W + 1)'(1);
            // reload wins over a stray byte offered on the same edge
            if (r_state == S_RUN) begin
                if (bus.reload) begin
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                    r_err    <= 1'b0;
                end else if (bus.load_valid) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // contents deliberately survive reset so an aborted load leaves its partial image
    always_ff @(posedge clock) begin
        if (reset && (w_accept || w_fill))
            r_mem[r_wr_ptr] <= w_fill ? 8'h00 : bus.load_data;
    end

    assign bus.cpu_data    = r_mem[bus.cpu_addr];
    assign bus.load_ready  = (r_state == S_LOAD);
    assign bus.loading     = (r_state != S_RUN);
    assign bus.cpu_reset_n = r_cpu_reset_n;
    assign bus.load_count  = r_count;
    assign bus.load_err    = r_err;
endmodule

// File: tb/tb_tw4_prog_loader.sv
// tb_tw4_prog_loader: directed, table-driven and random checks of the TW4 program loader.
module tb_tw4_prog_loader;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tw4_prog_loader_if #(.ADDR_W(6)) bus ();
    tw4_prog_loader #(.DEPTH(64), .ADDR_W(6)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    // reference model: phase 0=loading, 1=zero-padding, 2=running
    logic [7:0] m_mem [64];
    bit         m_known [64];
    int         m_phase = 0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    bit         m_err = 0;
    bit         m_rstn = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        int         cnt;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic tick();
        if (!reset) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
        end else if (m_phase == 0) begin
            if (bus.load_valid) begin
                m_mem[m_ptr] = bus.load_data;
                m_known[m_ptr] = 1;
                m_ptr++; m_cnt++;
                if (m_ptr == 64) m_phase = 2;
                else if (bus.load_last) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_mem[m_ptr] = 8'h00;
            m_known[m_ptr] = 1;
            m_ptr++;
            if (m_ptr == 64) m_phase = 2;
        end else begin
            if (bus.reload) begin
                m_phase = 0; m_ptr = 0; m_cnt = 0; m_err = 0;
            end else if (bus.load_valid) m_err = 1;
        end
        m_rstn = reset && (m_phase == 2);
        @(posedge clock);
        #1;
        chk("ready", 32'(bus.load_ready), 32'(m_phase == 0));
        chk("loading", 32'(bus.loading), 32'(m_phase != 2));
        chk("cpu_reset_n", 32'(bus.cpu_reset_n), 32'(m_rstn));
        chk("load_count", 32'(bus.load_count), 32'(m_cnt));
        chk("load_err", 32'(bus.load_err), 32'(m_err));
        if (m_known[bus.cpu_addr]) chk("cpu_data", 32'(bus.cpu_data), 32'(m_mem[bus.cpu_addr]));
    endtask

    task automatic idle();
        bus.load_valid = 0; bus.load_last = 0; bus.reload = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bus.load_valid = 1; bus.load_data = d; bus.load_last = l;
        tick();
        idle();
    endtask

    task automatic rd(input int a, input logic [7:0] e, input string n);
        bus.cpu_addr = 6'(a);
        #1;
        chk(n, 32'(bus.cpu_data), 32'(e));
    endtask

    task automatic wait_run(input string n, output int cycles);
        cycles = 0;
        while (!bus.cpu_reset_n && cycles < 100) begin
            tick();
            cycles++;
        end
        if (!bus.cpu_reset_n) chk({n, "_timeout"}, 32'(bus.cpu_reset_n), 32'd1);
    endtask

    task automatic do_reload();
        bus.reload = 1;
        tick();
        idle();
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1};
        tbl[1] = '{1'b0, 8'hFF, 1'b0, 1};
        tbl[2] = '{1'b1, 8'hA2, 1'b0, 2};
        tbl[3] = '{1'b0, 8'hFF, 1'b0, 2};
        tbl[4] = '{1'b1, 8'hA3, 1'b1, 3};
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        idle();
        bus.load_data = 0;
        bus.cpu_addr = 0;

        tick(); tick();
        reset = 1;
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_loading", 32'(bus.loading), 32'd1);
        chk("rst_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);
        chk("rst_count", 32'(bus.load_count), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);

        send(8'h31, 0); send(8'h52, 0); send(8'hF0, 1);
        chk("t2_count", 32'(bus.load_count), 32'd3);
        wait_run("t2", n);
        chk("t2_latency", 32'(n + 3), 32'd64);
        rd(1, 8'h52, "t2_rd1");
        rd(2, 8'hF0, "t2_rd2");
        rd(10, 8'h00, "t2_rd10");

        send(8'h77, 0);
        chk("t5_err", 32'(bus.load_err), 32'd1);
        rd(0, 8'h31, "t5_rd0");
        rd(2, 8'hF0, "t5_rd2");
        do_reload();
        chk("t5_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);
        chk("t5_ready", 32'(bus.load_ready), 32'd1);
        chk("t5_err_clr", 32'(bus.load_err), 32'd0);
        chk("t5_count", 32'(bus.load_count), 32'd0);

        for (int i = 0; i < 5; i++) begin
            bus.load_valid = tbl[i].v; bus.load_data = tbl[i].d; bus.load_last = tbl[i].l;
            tick();
            chk("t3_count", 32'(bus.load_count), 32'(tbl[i].cnt));
        end
        idle();
        wait_run("t3", n);
        rd(0, 8'hA1, "t3_rd0");
        rd(1, 8'hA2, "t3_rd1");
        rd(2, 8'hA3, "t3_rd2");
        rd(3, 8'h00, "t3_rd3");
        do_reload();

        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("t4_before_last", 32'(bus.cpu_reset_n), 32'd0);
            send(8'(i), 0);
        end
        chk("t4_run", 32'(bus.cpu_reset_n), 32'd1);
        chk("t4_count", 32'(bus.load_count), 32'd64);
        rd(63, 8'h3F, "t4_rd63");
        do_reload();

        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 0);
        reset = 0;
        bus.load_valid = 1; bus.load_data = 8'hEE;
        tick();
        idle();
        reset = 1;
        chk("t6_count", 32'(bus.load_count), 32'd0);
        chk("t6_ready", 32'(bus.load_ready), 32'd1);
        for (int i = 0; i < 5; i++) rd(i, 8'h10 + 8'(i), "t6_keep");
        send(8'hC0, 0); send(8'hC1, 1);
        wait_run("t6", n);
        rd(0, 8'hC0, "t6_rd0");
        rd(1, 8'hC1, "t6_rd1");
        rd(2, 8'h00, "t6_rd2");
        rd(4, 8'h00, "t6_rd4");

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            bus.load_valid = ($urandom_range(0, 1) == 1);
            bus.load_data = 8'($urandom);
            bus.load_last = ($urandom_range(0, 15) == 0);
            bus.reload = ($urandom_range(0, 19) == 0);
            bus.cpu_addr = 6'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tw4_prog_loader.md
# tw4_prog_loader

Program memory and boot loader sitting directly upstream of the TW4 CPU core. Holds a 64 × 8-bit instruction store, opcode in [7:4] and immediate in [3:0]. Fills the store from a byte-wide valid/ready load stream and zero-pads the unused tail. Holds the CPU in reset until the program is complete, then serves instruction bytes to the core's fetch address with a combinational read.

## Interface
Parameters:
- DEPTH, 64: number of instruction words; must equal 2**ADDR_W.
- ADDR_W, 6: physical fetch address width, mode[1:0] concatenated with addr[3:0].

Ports:
- clock  in  1  system clock, all state changes on the rising edge.
- reset  in  1  synchronous, active-low.
- load_valid  in  1  load byte offered.
- load_data  in  8  instruction byte.
- load_last  in  1  qualifies load_data as the final program byte.
- load_ready  out  1  loader accepts a byte this cycle.
- reload  in  1  single-cycle request to re-enter loading from RUN.
- cpu_addr  in  ADDR_W  CPU physical fetch address.
- cpu_data  out  8  instruction word at cpu_addr.
- cpu_reset_n  out  1  registered reset to the CPU, active-low.
- loading  out  1  high while the state is LOAD or FILL.
- load_count  out  ADDR_W+1  number of bytes accepted since the last load start.
- load_err  out  1  sticky; set when load_valid is high in RUN.

## Operation
- States: LOAD, FILL, RUN. Reset (reset==0 at an edge) sets:
  - state=LOAD, wr_ptr=0, load_count=0
  - cpu_reset_n=0, load_err=0
  - memory contents are not cleared.
- LOAD:
  - load_ready=1 (combinational from state).
  - Handshake: a byte is accepted on an edge where load_valid && load_ready. At that edge: mem[wr_ptr]<=load_data, wr_ptr and load_count increment.
  - Accepting with load_last=1 at wr_ptr<DEPTH-1 -> FILL.
  - Accepting with wr_ptr==DEPTH-1, with or without last -> RUN.
  - Idle cycles (load_valid=0) cause no change.
- FILL:
  - load_ready=0.
  - Each cycle writes mem[wr_ptr]<=8'h00 (ADD A,0) and increments wr_ptr; load_count is frozen.
  - The write at wr_ptr==DEPTH-1 -> RUN.
- RUN:
  - load_ready=0.
  - load_valid=1 at an edge sets load_err (sticky); the byte is dropped.
  - reload=1 -> LOAD: wr_ptr=0, load_count=0, load_err=0.
  - reload is ignored in LOAD and FILL.
- cpu_data = mem[cpu_addr] combinationally in all states. Reads are unaffected by loading; the CPU is held in reset meanwhile.
- cpu_reset_n <= (next_state==RUN). It rises on the same edge that enters RUN and falls on the edge that leaves it.
- loading = (state!=RUN).
- Width rules:
  - wr_ptr is ADDR_W bits and never wraps; the exits at DEPTH-1 precede overflow.
  - load_count is ADDR_W+1 bits, so 64 is representable.

## Timing
- Load latency: N bytes (last at index N-1, N<DEPTH) accepted on N handshake edges, then DEPTH-N FILL edges; cpu_reset_n high after the final FILL edge.
- N==DEPTH: no FILL cycles; cpu_reset_n high on the edge accepting byte 63.
- Memory write visible on cpu_data the cycle after its write edge.
- Reset has priority over every input on the same edge, including a handshake or reload.
- reset asserted mid-LOAD or mid-FILL aborts; the partial program stays in memory, and the next load overwrites from address 0.

## Test plan
1. Reset: hold reset=0 2 cycles -> load_ready=1, loading=1, cpu_reset_n=0, load_count=0, load_err=0 after release.
2. Short program: bytes 0x31, 0x52, 0xF0 (last on 0xF0) on consecutive cycles -> load_count=3, then 61 FILL cycles -> cpu_reset_n=1 exactly 64 edges after the first accept. Expected reads: cpu_addr=1 gives 0x52; cpu_addr=2 gives 0xF0; cpu_addr=10 gives 0x00.
3. Gapped stream: load_valid pattern 1,0,1,0,1 with data 0xA1, 0xFF, 0xA2, 0xFF, 0xA3 (last on final) -> mem[0..2]=A1, A2, A3; 0xFF is never written; load_count=3.
4. Full image: 64 bytes 0x00..0x3F with no load_last -> no FILL; cpu_reset_n=1 on the 64th accept edge; load_count=64; cpu_addr=63 gives 0x3F.
5. RUN protection: in RUN, pulse load_valid with 0x77 -> load_err=1 and memory unchanged. Then pulse reload -> next edge: cpu_reset_n=0, load_ready=1, load_err=0, load_count=0.
6. Reset mid-load: assert reset after 5 accepted bytes -> state LOAD, load_count=0, mem[0..4] retained. Reload 2 bytes (last) -> mem[0..1] new, rest zero-filled, RUN reached.
